// File: rtl/rvfi_reg_source_pkg.sv
// Shared constants and the channel-slice helper for the RVFI register source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvfi_reg_source_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREGS     = 32;
    localparam int ORDER_W   = 64;

    // Low bit of channel `ch` inside a flat per-channel vector of `width`-bit lanes.
    function automatic int ch_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rvfi_reg_source_fwd.sv
// Per-channel rs1/rs2 read network: shadow file plus same-beat writes of lower channels.
// Latency: purely combinational.
// Backpressure: none; consumer decides when results are used.
//
// Ports:
//   i_shadow            architectural register file (entry 0 is never written)
//   i_valid             per-channel retire valid
//   i_rs1/rs2/rd_addr   per-channel register indices, flat NRET*5
//   i_rd_wdata          per-channel rd write data, flat NRET*XLEN
//   o_rs1/rs2_rdata     per-channel read data after channel-order forwarding
module rvfi_reg_source_fwd
    import rvfi_reg_source_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NRET = 1
) (
    input  logic [NREGS-1:0][XLEN-1:0]  i_shadow,
    input  logic [NRET-1:0]             i_valid,
    input  logic [NRET*REG_IDX_W-1:0]   i_rs1_addr,
    input  logic [NRET*REG_IDX_W-1:0]   i_rs2_addr,
    input  logic [NRET*REG_IDX_W-1:0]   i_rd_addr,
    input  logic [NRET*XLEN-1:0]        i_rd_wdata,
    output logic [NRET*XLEN-1:0]        o_rs1_rdata,
    output logic [NRET*XLEN-1:0]        o_rs2_rdata
);

    logic [REG_IDX_W-1:0] w_a1;
    logic [REG_IDX_W-1:0] w_a2;
    logic [REG_IDX_W-1:0] w_wr;
    logic [XLEN-1:0]      w_d1;
    logic [XLEN-1:0]      w_d2;
    logic [NRET*XLEN-1:0] w_rs1_rdata;
    logic [NRET*XLEN-1:0] w_rs2_rdata;

    always_comb begin
        w_rs1_rdata = '0;
        w_rs2_rdata = '0;
        w_a1        = '0;
        w_a2        = '0;
        w_wr        = '0;
        w_d1        = '0;
        w_d2        = '0;
        for (int c = 0; c < NRET; c++) begin
            w_a1 = i_rs1_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W];
            w_a2 = i_rs2_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W];
            w_d1 = (w_a1 == '0) ? '0 : i_shadow[w_a1];
            w_d2 = (w_a2 == '0) ? '0 : i_shadow[w_a2];
            // Walk lower channels in ascending order so the highest earlier writer wins.
            for (int k = 0; k < c; k++) begin
                w_wr = i_rd_addr[ch_lo(k, REG_IDX_W) +: REG_IDX_W];
                if (i_valid[k] && (w_wr != '0)) begin
                    if (w_wr == w_a1) w_d1 = i_rd_wdata[ch_lo(k, XLEN) +: XLEN];
                    if (w_wr == w_a2) w_d2 = i_rd_wdata[ch_lo(k, XLEN) +: XLEN];
                end
            end
            w_rs1_rdata[ch_lo(c, XLEN) +: XLEN] = w_d1;
            w_rs2_rdata[ch_lo(c, XLEN) +: XLEN] = w_d2;
        end
    end

    assign o_rs1_rdata = w_rs1_rdata;
    assign o_rs2_rdata = w_rs2_rdata;

endmodule

// File: rtl/rvfi_reg_source.sv
// Retire-event to RVFI register-field source with shadow register file and order counter.
// Latency: 1 cycle from accept to rvfi_* outputs.
// Backpressure: in_ready = output empty or out_ready; outputs, shadow and counter hold while stalled.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   per-channel retire valid, single all-channel ready
//   in_rs1/rs2/rd_addr  register indices, in_rd_wdata rd write data
//   out_ready           sink accepts the registered output stage
//   rvfi_*              registered RVFI valid/order/address/data fields
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif

module rvfi_reg_source
    import rvfi_reg_source_pkg::*;
#(
    parameter int XLEN = `RISCV_FORMAL_XLEN,
    parameter int NRET = `RISCV_FORMAL_NRET
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRET-1:0]             in_valid,
    output logic                        in_ready,
    input  logic [NRET*REG_IDX_W-1:0]   in_rs1_addr,
    input  logic [NRET*REG_IDX_W-1:0]   in_rs2_addr,
    input  logic [NRET*REG_IDX_W-1:0]   in_rd_addr,
    input  logic [NRET*XLEN-1:0]        in_rd_wdata,
    input  logic                        out_ready,
    output logic [NRET-1:0]             rvfi_valid,
    output logic [NRET*ORDER_W-1:0]     rvfi_order,
    output logic [NRET*REG_IDX_W-1:0]   rvfi_rs1_addr,
    output logic [NRET*REG_IDX_W-1:0]   rvfi_rs2_addr,
    output logic [NRET*REG_IDX_W-1:0]   rvfi_rd_addr,
    output logic [NRET*XLEN-1:0]        rvfi_rs1_rdata,
    output logic [NRET*XLEN-1:0]        rvfi_rs2_rdata,
    output logic [NRET*XLEN-1:0]        rvfi_rd_wdata
);

    logic [NREGS-1:0][XLEN-1:0] r_shadow;
    logic [NREGS-1:0][XLEN-1:0] w_shadow_nxt;
    logic [ORDER_W-1:0]         r_order;
    logic [ORDER_W-1:0]         w_order_nxt;
    logic                       w_accept;
    logic [REG_IDX_W-1:0]       w_rd;

    logic [NRET*XLEN-1:0]       w_fwd_rs1;
    logic [NRET*XLEN-1:0]       w_fwd_rs2;

    logic [NRET-1:0]            w_valid;
    logic [NRET*ORDER_W-1:0]    w_order;
    logic [NRET*REG_IDX_W-1:0]  w_rs1_addr;
    logic [NRET*REG_IDX_W-1:0]  w_rs2_addr;
    logic [NRET*REG_IDX_W-1:0]  w_rd_addr;
    logic [NRET*XLEN-1:0]       w_rs1_rdata;
    logic [NRET*XLEN-1:0]       w_rs2_rdata;
    logic [NRET*XLEN-1:0]       w_rd_wdata;

    assign in_ready = (rvfi_valid == '0) | out_ready;
    assign w_accept = in_ready & (|in_valid);

    rvfi_reg_source_fwd #(
        .XLEN (XLEN),
        .NRET (NRET)
    ) u_fwd (
        .i_shadow    (r_shadow),
        .i_valid     (in_valid),
        .i_rs1_addr  (in_rs1_addr),
        .i_rs2_addr  (in_rs2_addr),
        .i_rd_addr   (in_rd_addr),
        .i_rd_wdata  (in_rd_wdata),
        .o_rs1_rdata (w_fwd_rs1),
        .o_rs2_rdata (w_fwd_rs2)
    );

    // Build the next output beat, next shadow file and next counter.
    // Invalid channels stay all-zero and consume no order number.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_order_nxt  = r_order;
        w_valid      = '0;
        w_order      = '0;
        w_rs1_addr   = '0;
        w_rs2_addr   = '0;
        w_rd_addr    = '0;
        w_rs1_rdata  = '0;
        w_rs2_rdata  = '0;
        w_rd_wdata   = '0;
        w_rd         = '0;
        for (int c = 0; c < NRET; c++) begin
            if (in_valid[c]) begin
                w_rd = in_rd_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W];
                w_valid[c] = 1'b1;
                w_order[ch_lo(c, ORDER_W) +: ORDER_W] = w_order_nxt;
                w_order_nxt = w_order_nxt + ORDER_W'(1);
                w_rs1_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W] = in_rs1_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W];
                w_rs2_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W] = in_rs2_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W];
                w_rd_addr[ch_lo(c, REG_IDX_W) +: REG_IDX_W]  = w_rd;
                w_rs1_rdata[ch_lo(c, XLEN) +: XLEN] = w_fwd_rs1[ch_lo(c, XLEN) +: XLEN];
                w_rs2_rdata[ch_lo(c, XLEN) +: XLEN] = w_fwd_rs2[ch_lo(c, XLEN) +: XLEN];
                if (w_rd != '0) begin
                    w_rd_wdata[ch_lo(c, XLEN) +: XLEN] = in_rd_wdata[ch_lo(c, XLEN) +: XLEN];
                    w_shadow_nxt[w_rd] = in_rd_wdata[ch_lo(c, XLEN) +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_order  <= '0;
        end else if (w_accept) begin
            r_shadow <= w_shadow_nxt;
            r_order  <= w_order_nxt;
        end
    end

    // Output stage reloads whenever it may advance; an idle beat loads all-zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvfi_valid     <= '0;
            rvfi_order     <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_wdata  <= '0;
        end else if (in_ready) begin
            rvfi_valid     <= w_valid;
            rvfi_order     <= w_order;
            rvfi_rs1_addr  <= w_rs1_addr;
            rvfi_rs2_addr  <= w_rs2_addr;
            rvfi_rd_addr   <= w_rd_addr;
            rvfi_rs1_rdata <= w_rs1_rdata;
            rvfi_rs2_rdata <= w_rs2_rdata;
            rvfi_rd_wdata  <= w_rd_wdata;
        end
    end

endmodule

// File: doc/rvfi_reg_source.md
Name: rvfi_reg_source

Overview:
- Producer-side companion to the RVFI register consistency check.
- Sits on a core's retire path, or in a bench stub, and accepts retirement events carrying register addresses and rd write data.
- Keeps an architectural shadow register file and fills in rs1/rs2 read data from it.
- Emits fully populated RVFI register fields plus rvfi_order through one registered output stage with valid/ready backpressure.

Parameters:
- XLEN, `RISCV_FORMAL_XLEN (32): register width.
- NRET, `RISCV_FORMAL_NRET (1): retire channels per cycle.

Ports:
- clock  in  1  — sole clock, rising edge.
- reset  in  1  — asynchronous, active-high reset.
- in_valid  in  NRET  — per-channel retire event valid.
- in_ready  out  1  — all in_valid channels accepted this cycle when high.
- in_rs1_addr  in  NRET*5  — rs1 index per channel.
- in_rs2_addr  in  NRET*5  — rs2 index per channel.
- in_rd_addr  in  NRET*5  — rd index per channel.
- in_rd_wdata  in  NRET*XLEN  — rd write value per channel.
- out_ready  in  1  — sink accepts the output stage.
- rvfi_valid  out  NRET  — registered.
- rvfi_order  out  NRET*64  — retire sequence number.
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  NRET*5 each.
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  out  NRET*XLEN each.

Behaviour:
- Reset, asynchronous:
  - All 32 shadow registers = 0; order counter = 0.
  - All rvfi_* outputs = 0, so rvfi_valid = 0.
  - in_ready = 1 combinationally once reset deasserts.
- Handshake:
  - in_ready = (rvfi_valid == 0) | out_ready.
  - An accept occurs on a rising edge where in_ready && |in_valid.
  - Input fields are don't-care when in_valid[c] = 0.
- Output stage:
  - On accept, all rvfi_* are loaded next edge; latency is exactly 1 cycle.
  - When in_ready && in_valid == 0, rvfi_valid clears next edge.
  - When out_ready = 0 and rvfi_valid != 0, all outputs hold stable.
- Read data:
  - Channel c reads shadow[rs] after applying the writes of lower-numbered valid channels in the same beat, i.e. channel-order forwarding.
  - The highest earlier channel writing that index wins.
  - Index 0 always reads 0.
- Write:
  - For valid channel c with rd != 0, shadow[rd] takes in_rd_wdata at the accept edge; the last valid channel wins on collision.
  - rd = 0: no write, and the emitted rvfi_rd_wdata is forced to 0.
  - rvfi_rd_addr passes through unchanged, including 0.
- Order:
  - Valid channels take consecutive numbers starting at the counter value, in ascending channel index. Gaps in in_valid are allowed and are skipped, not numbered.
  - The counter advances by popcount(in_valid) per accept, wraps modulo 2^64, and does not advance on a stall.
  - Invalid channels output order 0 and all fields 0.
- Stall: the shadow file and counter are unchanged while in_ready = 0. A retire event is never double-applied.
- Reset mid-stall: the held output is discarded, with no partial state.

Decomposition:
- Package rvfi_reg_source_pkg:
  - REG_IDX_W = 5; NREGS = 32; ORDER_W = 64.
  - A channel-slice helper function for the addr/data sub-vectors.
- Sub-module rvfi_reg_source_fwd: combinational per-channel forwarding and read-mux network over the shadow array and lower-channel writes. It is instantiated once in the top level.
- The shadow array, counter and output register live in the top level.

Test Plan:
- Basic write/read: NRET = 1, out_ready = 1. Retire {rd=5, wdata=0xDEADBEEF}, then {rs1=5, rs2=0}. Second output: rs1_rdata = 0xDEADBEEF, rs2_rdata = 0, orders 0 and 1, each 1 cycle after accept.
- x0 handling: retire {rd=0, wdata=0x1234}, then {rs1=0}. First output rd_wdata = 0; second output rs1_rdata = 0.
- Backpressure: hold out_ready = 0 for 3 cycles after one accept. in_ready = 0 for those cycles and outputs stay frozen. Pulse in_valid during the stall: no extra order increment, no shadow update. On release, the next event gets order 1.
- Same-beat forwarding (NRET = 2): ch0 {rd=3, wdata=0xA}, ch1 {rs1=3, rd=3, wdata=0xB}. Output ch1 rs1_rdata = 0xA, orders 0 and 1. The next beat rs1=3 reads 0xB.
- Sparse valid (NRET = 2): in_valid = 2'b10 → ch1 order = current counter, ch0 all zero, counter advances by 1.
- Async reset mid-run: after writes to x7, assert reset between edges. rvfi_valid drops immediately; the next x7 read = 0 and order restarts at 0.
